// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared state type and bundle size for the word serializer
package word_serializer_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int NUM_WORDS = 4;
endpackage

// File: rtl/mux_4_1.sv
// mux_4_1: W-wide 4:1 multiplexer
module mux_4_1 #(
    parameter int W = 4
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  logic [1:0]   sel_i,
    output logic [W-1:0] y_o
);
    always_comb y_o = sel_i[1] ? (sel_i[0] ? d3_i : d2_i) : (sel_i[0] ? d1_i : d0_i);
endmodule

// File: rtl/word_serializer_4.sv
// word_serializer_4: accepts a bundle of up to four words and emits them one beat at a time
module word_serializer_4
    import word_serializer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_d0,
    input  logic [W-1:0] in_d1,
    input  logic [W-1:0] in_d2,
    input  logic [W-1:0] in_d3,
    input  logic [1:0]   in_len,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    output logic         out_last
);
    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d, len_q;
    logic [W-1:0] d_q [NUM_WORDS];
    logic         accept, take;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = SEND;
        else if (take && out_last) state_d = IDLE;
    end

    // Ready is granted during the final beat so a new bundle follows without a bubble
    always_comb begin
        out_valid = state_q == SEND;
        out_last  = out_valid && cnt_q == len_q;
        in_ready  = !out_valid || (out_last && out_ready);
        out_sel   = cnt_q;
    end

    always_comb cnt_d = accept ? 2'd0 : (take && !out_last) ? cnt_q + 2'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            len_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++) d_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                len_q  <= in_len;
                d_q[0] <= in_d0;
                d_q[1] <= in_d1;
                d_q[2] <= in_d2;
                d_q[3] <= in_d3;
            end
        end
    end

    mux_4_1 #(.W(W)) u_mux (
        .d0_i  (d_q[0]),
        .d1_i  (d_q[1]),
        .d2_i  (d_q[2]),
        .d3_i  (d_q[3]),
        .sel_i (cnt_q),
        .y_o   (out_data)
    );
endmodule

// File: tb/tb_word_serializer_4.sv
// tb_word_serializer_4: directed self-checking bench for word_serializer_4
module tb_word_serializer_4;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [3:0] in_d0 = 0, in_d1 = 0, in_d2 = 0, in_d3 = 0;
    logic [1:0] in_len = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_last;
    int         checks = 0;
    int         errors = 0;

    word_serializer_4 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .in_d3     (in_d3),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, b, c, d, input logic [1:0] l);
        in_d0 = a; in_d1 = b; in_d2 = c; in_d3 = d; in_len = l; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    // With out_ready high, in_ready mirrors out_last during a beat
    task automatic beat(input logic [3:0] d, input logic [1:0] s, input logic l);
        @(negedge clk);
        check("beat_valid", out_valid, 1);
        check("beat_data", out_data, d);
        check("beat_sel", out_sel, s);
        check("beat_last", out_last, l);
        check("beat_in_ready", in_ready, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data", out_data, 0);
        check("rst_sel", out_sel, 0);
        check("rst_last", out_last, 0);
        @(negedge clk);
        rst_n = 1;

        send(4'ha, 4'hb, 4'hc, 4'hd, 2'd3);
        beat(4'ha, 0, 0); beat(4'hb, 1, 0); beat(4'hc, 2, 0); beat(4'hd, 3, 1);
        idle_check("full_end");

        send(4'd7, 4'd10, 4'd3, 4'd5, 2'd1);
        beat(4'd7, 0, 0); beat(4'd10, 1, 1);
        idle_check("len1_end");

        send(4'd1, 4'd2, 4'd3, 4'd4, 2'd3);
        beat(4'd1, 0, 0); beat(4'd2, 1, 0);
        out_ready = 0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 3);
            check("stall_sel", out_sel, 2);
            check("stall_last", out_last, 0);
            check("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        beat(4'd3, 2, 0); beat(4'd4, 3, 1);
        idle_check("stall_end");

        in_d0 = 1; in_d1 = 2; in_d2 = 3; in_d3 = 4; in_len = 3; in_valid = 1;
        @(posedge clk);
        #1 in_d0 = 5; in_d1 = 6; in_d2 = 7; in_d3 = 8;
        for (int i = 0; i < 4; i++) beat(4'(i + 1), 2'(i), i == 3);
        in_valid = 0;
        for (int i = 0; i < 4; i++) beat(4'(i + 5), 2'(i), i == 3);
        idle_check("b2b_end");

        send(4'h9, 4'ha, 4'hb, 4'hc, 2'd3);
        beat(4'h9, 0, 0);
        @(negedge clk);
        check("mid_sel", out_sel, 1);
        check("mid_data", out_data, 4'ha);
        #2 rst_n = 0;
        #1;
        check("mres_valid", out_valid, 0);
        check("mres_last", out_last, 0);
        check("mres_sel", out_sel, 0);
        check("mres_data", out_data, 0);
        #1 rst_n = 1;
        repeat (4) idle_check("post_rst");

        send(4'ha, 4'hb, 4'hc, 4'hd, 2'd3);
        in_d0 = 4'hf; in_d1 = 4'hf; in_d2 = 4'hf; in_d3 = 4'hf; in_len = 0;
        beat(4'ha, 0, 0); beat(4'hb, 1, 0); beat(4'hc, 2, 0); beat(4'hd, 3, 1);
        idle_check("chg_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/word_serializer_4.md
WORD_SERIALIZER_4 -- requirements
Module: word_serializer_4

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, upstream presents a 4-word bundle.
REQ-005 The block SHALL have port in_ready, output, 1, the block accepts the bundle this cycle.
REQ-006 The block SHALL have ports in_d0, in_d1, in_d2, in_d3, input, W each, bundle words; in_d0 is sent first.
REQ-007 The block SHALL have port in_len, input, 2, number of beats minus one (0 = send in_d0 only, 3 = all four).
REQ-008 The block SHALL have port out_valid, output, 1, out_data holds a valid beat.
REQ-009 The block SHALL have port out_ready, input, 1, downstream takes the beat this cycle.
REQ-010 The block SHALL have port out_data, output, W, current beat word.
REQ-011 The block SHALL have port out_sel, output, 2, index of the current beat (0..3).
REQ-012 The block SHALL have port out_last, output, 1, current beat is the final beat of the bundle.

Function
REQ-013 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; words and in_len SHALL be captured into internal registers at that edge.
REQ-014 The FSM SHALL have two states: IDLE (no bundle held) and SEND (bundle held, beats pending).
REQ-015 IDLE -> SEND on acceptance; SEND -> IDLE on the edge where the last beat is taken (out_valid, out_ready, out_last all 1) with no simultaneous acceptance; SEND -> SEND otherwise.
REQ-016 in_ready SHALL be 1 in IDLE, and in SEND only when out_last and out_ready are both 1 (back-to-back bundles, no bubble); 0 otherwise; in_ready SHALL NOT depend on in_valid.
REQ-017 out_valid SHALL be 1 exactly when the state is SEND; latency from acceptance edge to first out_valid SHALL be zero cycles after that edge (visible in the following cycle).
REQ-018 A 2-bit beat counter SHALL load 0 on acceptance and increment by 1 on each beat taken that is not the last beat; out_sel SHALL equal the counter.
REQ-019 out_data SHALL be the captured word selected by the counter (0 -> d0, 1 -> d1, 2 -> d2, 3 -> d3), combinational from registers.
REQ-020 out_last SHALL be 1 when in SEND and counter equals captured in_len; 0 in IDLE.
REQ-021 When out_valid is 1 and out_ready is 0, out_data, out_sel, out_last SHALL hold stable until the beat is taken.
REQ-022 Counter SHALL never wrap past captured in_len; with in_len = 3 the final beat is sel 3 and the counter reloads to 0 only on acceptance.
REQ-023 Changes on in_d*/in_len outside an acceptance edge SHALL NOT affect outputs.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state IDLE, counter 0, out_valid 0, out_last 0, out_sel 0, in_ready 1 after release; data registers SHALL reset to 0 so out_data reads 0.
REQ-025 Reset mid-bundle SHALL discard remaining beats; no beat of that bundle SHALL appear after rst_n deasserts.
REQ-026 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package word_serializer_pkg SHALL hold the state enum type (IDLE, SEND) and the constant for the number of words (4).
REQ-028 Beat selection SHALL be a single instance of the team's existing 4:1 mux sub-module mux_4_1, driven by the counter as select; at W other than 4 an equivalent W-wide mux is used.
REQ-029 Counter, state and data registers SHALL be in this module; no other sub-modules.

Verification
REQ-030 Bench SHALL cover: reset, then bundle {a,b,c,d}, in_len=3, out_ready=1 -> out_data a,b,c,d on four consecutive cycles, out_sel 0..3, out_last only on d, then out_valid 0.
REQ-031 Bench SHALL cover: bundle {7,10,3,5}, in_len=1 -> beats 7, 10 only, out_last on 10, in_ready 1 the cycle after.
REQ-032 Bench SHALL cover: out_ready=0 for 3 cycles at sel 2 of {1,2,3,4} -> out_data holds 3, out_sel holds 2, in_ready 0; resumes with 4 after out_ready=1.
REQ-033 Bench SHALL cover: in_valid held 1 with bundles {1,2,3,4} then {5,6,7,8}, in_len=3 -> eight consecutive beats 1..8, no out_valid gap, second accept on sel-3 beat of first.
REQ-034 Bench SHALL cover: rst_n pulsed low at sel 1 of {9,a,b,c} -> out_valid 0 immediately, no 'hb or 'hc emitted after release, in_ready 1.
REQ-035 Bench SHALL cover: in_d* changed while in SEND with bundle {a,b,c,d} in_len=3 -> beats remain a,b,c,d.
